// File: rtl/vga_sync_monitor_if.sv
// vga_sync_monitor_if: VGA sync inputs and measurement/status results of the sync monitor
interface vga_sync_monitor_if;
   logic        i_hs;
   logic        i_vs;
   logic        i_blank_n;
   logic [11:0] o_line_ticks;
   logic [11:0] o_hs_ticks;
   logic [9:0]  o_lines;
   logic [3:0]  o_vs_lines;
   logic [9:0]  o_active_lines;
   logic [15:0] o_frame_cnt;
   logic        o_meas_valid;
   logic        o_locked;
   logic        o_err;
   logic        o_err_sticky;

   modport master (
      output i_hs, i_vs, i_blank_n,
      input  o_line_ticks, o_hs_ticks, o_lines, o_vs_lines, o_active_lines,
      input  o_frame_cnt, o_meas_valid, o_locked, o_err, o_err_sticky
   );

   modport slave (
      input  i_hs, i_vs, i_blank_n,
      output o_line_ticks, o_hs_ticks, o_lines, o_vs_lines, o_active_lines,
      output o_frame_cnt, o_meas_valid, o_locked, o_err, o_err_sticky
   );
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures VGA sync timing against the expected mode and reports lock/error status
module vga_sync_monitor #(
   parameter int EXP_LINE_TICKS = 1600,
   parameter int EXP_HS_TICKS   = 192,
   parameter int EXP_LINES      = 525,
   parameter int EXP_VS_LINES   = 2,
   parameter int TOL            = 4,
   parameter int LOCK_FRAMES    = 2
) (
   input logic               CLOCK_50,
   input logic               RST_N,
   vga_sync_monitor_if.slave bus
);
   localparam logic [11:0] LINE_LO  = 12'(EXP_LINE_TICKS - TOL);
   localparam logic [11:0] LINE_HI  = 12'(EXP_LINE_TICKS + TOL);
   localparam logic [11:0] HS_LO    = 12'(EXP_HS_TICKS - TOL);
   localparam logic [11:0] HS_HI    = 12'(EXP_HS_TICKS + TOL);
   localparam logic [9:0]  LINES    = 10'(EXP_LINES);
   localparam logic [3:0]  VS_LINES = 4'(EXP_VS_LINES);
   localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t      state;
   logic [1:0]  hs_sync, vs_sync, bl_sync;
   logic        hs_lvl, vs_lvl, bl_lvl;
   logic        hs_fall, hs_rise, vs_fall;
   logic [11:0] tick_cnt;
   logic [9:0]  line_cnt, act_cnt, line_nx, act_nx;
   logic [3:0]  vs_line_cnt, vs_nx;
   logic [7:0]  good_cnt;
   logic        seen_active, armed, frame_bad;
   logic        timeout, line_bad, width_bad, bad_nx, frame_end, frame_ok;

   // two-flop synchronizers followed by level registers and edge strobes aligned to those levels
   always_ff @(posedge CLOCK_50 or negedge RST_N)
      if (!RST_N) begin
         hs_sync <= 2'b11;
         vs_sync <= 2'b11;
         bl_sync <= 2'b11;
         hs_lvl  <= 1'b1;
         vs_lvl  <= 1'b1;
         bl_lvl  <= 1'b1;
         hs_fall <= 1'b0;
         hs_rise <= 1'b0;
         vs_fall <= 1'b0;
      end else begin
         hs_sync <= {hs_sync[0], bus.i_hs};
         vs_sync <= {vs_sync[0], bus.i_vs};
         bl_sync <= {bl_sync[0], bus.i_blank_n};
         hs_lvl  <= hs_sync[1];
         vs_lvl  <= vs_sync[1];
         bl_lvl  <= bl_sync[1];
         hs_fall <= hs_lvl & ~hs_sync[1];
         hs_rise <= ~hs_lvl & hs_sync[1];
         vs_fall <= vs_lvl & ~vs_sync[1];
      end

   // next-value view of the frame counters so a line ending on the VS edge lands in the ending frame
   always_comb begin
      timeout   = tick_cnt == 12'd4094 && !hs_fall;
      line_bad  = hs_fall && armed && (tick_cnt < LINE_LO || tick_cnt > LINE_HI);
      width_bad = hs_rise && state != SEARCH && (tick_cnt < HS_LO || tick_cnt > HS_HI);
      line_nx   = line_cnt + 10'(hs_fall && line_cnt != 10'h3ff);
      vs_nx     = vs_line_cnt + 4'(hs_fall && !vs_lvl && vs_line_cnt != 4'hf);
      act_nx    = act_cnt + 10'(hs_fall && seen_active && act_cnt != 10'h3ff);
      bad_nx    = frame_bad | line_bad | width_bad;
      frame_end = vs_fall && state != SEARCH && !timeout;
      frame_ok  = !bad_nx && line_nx == LINES && vs_nx == VS_LINES;
   end

   // tick timing, per-line measurements and per-frame accumulators (held clear while searching)
   always_ff @(posedge CLOCK_50 or negedge RST_N)
      if (!RST_N) begin
         tick_cnt         <= '0;
         seen_active      <= 1'b0;
         armed            <= 1'b0;
         line_cnt         <= '0;
         vs_line_cnt      <= '0;
         act_cnt          <= '0;
         frame_bad        <= 1'b0;
         bus.o_line_ticks <= '0;
         bus.o_hs_ticks   <= '0;
      end else begin
         tick_cnt    <= hs_fall ? 12'd1 : tick_cnt + 12'(tick_cnt != 12'hfff);
         seen_active <= hs_fall ? bl_lvl : seen_active | bl_lvl;
         armed       <= state != SEARCH && (armed || hs_fall);
         if (hs_fall) bus.o_line_ticks <= tick_cnt;
         if (hs_rise) bus.o_hs_ticks <= tick_cnt;
         if (state == SEARCH || frame_end) begin
            line_cnt    <= '0;
            vs_line_cnt <= '0;
            act_cnt     <= '0;
            frame_bad   <= 1'b0;
         end else begin
            line_cnt    <= line_nx;
            vs_line_cnt <= vs_nx;
            act_cnt     <= act_nx;
            frame_bad   <= bad_nx;
         end
      end

   // frame evaluation, lock state machine and status pulses; a lost HS overrides everything
   always_ff @(posedge CLOCK_50 or negedge RST_N)
      if (!RST_N) begin
         state              <= SEARCH;
         good_cnt           <= '0;
         bus.o_lines        <= '0;
         bus.o_vs_lines     <= '0;
         bus.o_active_lines <= '0;
         bus.o_frame_cnt    <= '0;
         bus.o_meas_valid   <= 1'b0;
         bus.o_locked       <= 1'b0;
         bus.o_err          <= 1'b0;
         bus.o_err_sticky   <= 1'b0;
      end else begin
         bus.o_meas_valid <= frame_end;
         bus.o_err        <= timeout || (frame_end && !frame_ok);
         bus.o_err_sticky <= bus.o_err_sticky | bus.o_err;
         if (frame_end) begin
            bus.o_lines        <= line_nx;
            bus.o_vs_lines     <= vs_nx;
            bus.o_active_lines <= act_nx;
            bus.o_frame_cnt    <= bus.o_frame_cnt + 16'd1;
         end
         if (timeout) begin
            state        <= SEARCH;
            good_cnt     <= '0;
            bus.o_locked <= 1'b0;
         end else if (vs_fall && state == SEARCH) begin
            state <= MEASURE;
         end else if (frame_end && !frame_ok) begin
            state        <= MEASURE;
            good_cnt     <= '0;
            bus.o_locked <= 1'b0;
         end else if (frame_end && state == MEASURE) begin
            good_cnt <= good_cnt + 8'd1;
            if (good_cnt + 8'd1 >= LOCK_N) begin
               state        <= LOCKED;
               bus.o_locked <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: randomized frame stimulus with a frame-level reference model and scoreboard
module tb_vga_sync_monitor;
   localparam int LINE  = 48;
   localparam int HS    = 8;
   localparam int LINES = 20;
   localparam int VSL   = 2;
   localparam int TOL   = 2;
   localparam int LOCK  = 2;
   localparam int ACT_FIRST = 3;
   localparam int ACT_LAST  = 16;

   typedef struct {
      bit to;
      bit err;
      bit locked;
      bit sticky;
      int lines;
      int vsl;
      int act;
      int lt;
      int ht;
      int fc;
   } exp_t;

   logic CLOCK_50 = 1'b0;
   logic RST_N = 1'b0;
   vga_sync_monitor_if bus ();

   vga_sync_monitor #(
      .EXP_LINE_TICKS(LINE), .EXP_HS_TICKS(HS), .EXP_LINES(LINES),
      .EXP_VS_LINES(VSL), .TOL(TOL), .LOCK_FRAMES(LOCK)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RST_N(RST_N),
      .bus(bus)
   );

   initial forever #5 CLOCK_50 = ~CLOCK_50;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails = 0;

   bit m_meas, m_skip, m_sticky;
   int m_good, m_frames;
   bit p_bad;
   int p_lines, p_vsl, p_act, p_lt, p_ht;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_line_ticks"}, int'(bus.o_line_ticks), 0);
      chk({tag, "_hs_ticks"}, int'(bus.o_hs_ticks), 0);
      chk({tag, "_lines"}, int'(bus.o_lines), 0);
      chk({tag, "_vs_lines"}, int'(bus.o_vs_lines), 0);
      chk({tag, "_active_lines"}, int'(bus.o_active_lines), 0);
      chk({tag, "_frame_cnt"}, int'(bus.o_frame_cnt), 0);
      chk({tag, "_meas_valid"}, int'(bus.o_meas_valid), 0);
      chk({tag, "_locked"}, int'(bus.o_locked), 0);
      chk({tag, "_err"}, int'(bus.o_err), 0);
      chk({tag, "_err_sticky"}, int'(bus.o_err_sticky), 0);
   endtask

   task automatic model_reset();
      m_meas = 0;
      m_skip = 0;
      m_sticky = 0;
      m_good = 0;
      m_frames = 0;
   endtask

   task automatic drive_line(input int len, input int wid, input bit vs_low, input int act);
      for (int t = 0; t < len; t++) begin
         bus.i_hs = t >= wid;
         bus.i_vs = !vs_low;
         bus.i_blank_n = t >= 12 && t < 12 + act;
         @(negedge CLOCK_50);
      end
   endtask

   // a VS falling edge is about to start a frame: report the frame that it ends
   task automatic close_frame(input int vs_w);
      exp_t e;
      bit bad;
      if (m_meas) begin
         bad = p_bad || p_lines != LINES || p_vsl != VSL;
         m_good = bad ? 0 : m_good + 1;
         m_frames = (m_frames + 1) % 65536;
         e = '{default: 0};
         e.err = bad;
         e.locked = m_good >= LOCK;
         e.sticky = m_sticky;
         e.lines = p_lines;
         e.vsl = p_vsl;
         e.act = p_act;
         e.lt = p_lt;
         e.ht = p_ht;
         e.fc = m_frames;
         exp_q.push_back(e);
         if (bad) m_sticky = 1;
      end
      m_skip = !m_meas;
      m_meas = 1;
      p_bad = 0;
      p_lines = 0;
      p_vsl = vs_w;
      p_act = 0;
   endtask

   // kind: 0 nominal, 1 one bad line length, 2 bad HS width, 3 short frame, 4 HS loss, 5 wide VS
   task automatic run_frame(input int kind, input int stop);
      int n, vs_w, bad_line, to_line, len, wid, act;
      exp_t e;
      n = kind == 3 ? LINES - 1 : LINES;
      vs_w = kind == 5 ? VSL + 1 : VSL;
      bad_line = $urandom_range(0, n - 1);
      to_line = kind == 4 ? $urandom_range(3, n - 2) : n;
      close_frame(vs_w);
      for (int i = 0; i < n && i != stop; i++) begin
         if (i == to_line) begin
            e = '{default: 0};
            e.to = 1;
            e.err = 1;
            e.sticky = m_sticky;
            exp_q.push_back(e);
            m_sticky = 1;
            m_good = 0;
            m_meas = 0;
            drive_line(5000, HS, 0, 0);
            return;
         end
         len = $urandom_range(LINE - TOL, LINE + TOL);
         wid = $urandom_range(HS - TOL, HS + TOL);
         act = (i >= ACT_FIRST && i <= ACT_LAST) ? $urandom_range(1, 24) : 0;
         if (kind == 1 && i == bad_line)
            len = $urandom_range(0, 1) ? LINE + TOL + 1 + $urandom_range(0, 6)
                                       : LINE - TOL - 1 - $urandom_range(0, 6);
         if (kind == 2)
            wid = $urandom_range(0, 1) ? HS + TOL + 1 + $urandom_range(0, 4)
                                       : HS - TOL - 1 - $urandom_range(0, 4);
         if ((len < LINE - TOL || len > LINE + TOL) && !(m_skip && i == 0)) p_bad = 1;
         if (wid < HS - TOL || wid > HS + TOL) p_bad = 1;
         p_lines++;
         if (act > 0) p_act++;
         p_lt = len;
         p_ht = wid;
         drive_line(len, wid, i < vs_w, act);
      end
   endtask

   // scoreboard: every status pulse from the DUT must match the oldest expected event
   initial begin
      exp_t e;
      forever begin
         @(posedge CLOCK_50);
         #1;
         if (RST_N && (bus.o_meas_valid || bus.o_err)) begin
            chk("event_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("meas_valid", int'(bus.o_meas_valid), int'(!e.to));
               chk("err", int'(bus.o_err), int'(e.err));
               chk("locked", int'(bus.o_locked), int'(e.locked));
               chk("err_sticky", int'(bus.o_err_sticky), int'(e.sticky));
               if (!e.to) begin
                  chk("lines", int'(bus.o_lines), e.lines);
                  chk("vs_lines", int'(bus.o_vs_lines), e.vsl);
                  chk("active_lines", int'(bus.o_active_lines), e.act);
                  chk("line_ticks", int'(bus.o_line_ticks), e.lt);
                  chk("hs_ticks", int'(bus.o_hs_ticks), e.ht);
                  chk("frame_cnt", int'(bus.o_frame_cnt), e.fc);
               end
            end
         end
      end
   end

   initial begin
      int rk;
      bus.i_hs = 1'b1;
      bus.i_vs = 1'b1;
      bus.i_blank_n = 1'b0;
      model_reset();
      repeat (3) @(negedge CLOCK_50);
      check_zero("reset");
      RST_N = 1'b1;
      @(negedge CLOCK_50);
      repeat (4) run_frame(0, -1);
      run_frame(1, -1);
      repeat (3) run_frame(0, -1);
      repeat (3) run_frame(2, -1);
      repeat (3) run_frame(0, -1);
      run_frame(3, -1);
      repeat (3) run_frame(0, -1);
      run_frame(5, -1);
      repeat (3) run_frame(0, -1);
      run_frame(4, -1);
      repeat (4) run_frame(0, -1);
      for (int k = 0; k < 8; k++) begin
         rk = $urandom_range(0, 8);
         run_frame((rk > 5 || rk == 4) ? 0 : rk, -1);
      end
      run_frame(0, 6);
      bus.i_hs = 1'b1;
      bus.i_vs = 1'b1;
      bus.i_blank_n = 1'b0;
      chk("queue_before_reset", exp_q.size(), 0);
      #3;
      RST_N = 1'b0;
      #1;
      check_zero("mid_reset");
      exp_q.delete();
      model_reset();
      repeat (3) @(negedge CLOCK_50);
      RST_N = 1'b1;
      @(negedge CLOCK_50);
      repeat (4) run_frame(0, -1);
      close_frame(VSL);
      drive_line(20, HS, 1, 0);
      repeat (20) @(negedge CLOCK_50);
      chk("queue_drained", exp_q.size(), 0);
      chk("final_sticky", int'(bus.o_err_sticky), int'(m_sticky));
      chk("final_locked", int'(bus.o_locked), int'(m_good >= LOCK));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side checker for the VGA timing produced by the display path. It samples HSYNC, VSYNC and BLANK_N in the CLOCK_50 domain and measures line period, hsync width, lines per frame and vsync width. It compares each measurement against 640x480@60 expectations and reports lock and error status. It sits beside the VGA output on the top level, with results routed to LEDs/HEX, and serves as an on-board self-check of the sync generator.

## Interface
- EXP_LINE_TICKS, 1600: expected HS falling-to-falling period in CLOCK_50 ticks (800 px × 2)
- EXP_HS_TICKS, 192: expected HS low width in ticks (96 px × 2)
- EXP_LINES, 525: expected HS falling edges per frame
- EXP_VS_LINES, 2: expected HS falling edges seen while VS low
- TOL, 4: ± tick tolerance on line period and HS width
- LOCK_FRAMES, 2: consecutive good frames required for lock

Ports:
- CLOCK_50  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- i_hs  in  1  VGA_HS, active-low, asynchronous to CLOCK_50
- i_vs  in  1  VGA_VS, active-low, asynchronous
- i_blank_n  in  1  VGA_BLANK_N, asynchronous
- o_line_ticks  out  12  last measured line period
- o_hs_ticks  out  12  last measured HS low width
- o_lines  out  10  lines in last complete frame
- o_vs_lines  out  4  VS width of last frame, in lines
- o_active_lines  out  10  lines in last frame containing ≥1 tick of blank_n=1
- o_frame_cnt  out  16  complete frames measured, wraps 65535→0
- o_meas_valid  out  1  one-cycle pulse when frame results update
- o_locked  out  1  timing within spec for LOCK_FRAMES consecutive frames
- o_err  out  1  one-cycle pulse on each bad frame or timeout
- o_err_sticky  out  1  set on any o_err; cleared only by reset

## Operation
- Each input passes through a 2-flop synchronizer, then a registered edge detector producing hs_fall, hs_rise and vs_fall.
- tick_cnt (12b) resets to 1 on hs_fall and otherwise increments, saturating at 4095.
  - On hs_fall: o_line_ticks <= tick_cnt. The line is bad if the value is outside EXP_LINE_TICKS±TOL. The first hs_fall after SEARCH is not checked.
  - On hs_rise: o_hs_ticks <= tick_cnt. Bad if outside EXP_HS_TICKS±TOL.
- line_cnt (10b, saturating) increments on hs_fall.
  - vs_line_cnt (4b, saturating) increments on hs_fall while synced VS is 0.
  - act_cnt increments on hs_fall if blank_n was high at any time during the ending line.
- frame_bad flag: set by any bad line or HS-width measurement in the frame; cleared at vs_fall.
- On vs_fall in MEASURE or LOCKED:
  - Latch o_lines, o_vs_lines, o_active_lines.
  - Pulse o_meas_valid and increment o_frame_cnt.
  - The frame is bad if frame_bad, or line_cnt≠EXP_LINES, or vs_line_cnt≠EXP_VS_LINES.
  - Clear the per-frame counters.
- FSM states SEARCH, MEASURE, LOCKED:
  - SEARCH: counters held clear. First vs_fall → MEASURE, with no o_meas_valid and no check.
  - MEASURE: vs_fall with a good frame → good_cnt++. When good_cnt reaches LOCK_FRAMES → LOCKED. A bad frame → good_cnt=0, pulse o_err, stay in MEASURE.
  - LOCKED: bad frame → pulse o_err, good_cnt=0, → MEASURE.
  - Any state: tick_cnt reaching 4095 (no HS edge for 4095 ticks) → pulse o_err once, → SEARCH.
- o_locked = (state==LOCKED).
- Simultaneous hs_fall and vs_fall in the same cycle: the hs_fall line is counted into the ending frame before the frame is latched.

## Timing
- Reset values:
  - All outputs 0; state SEARCH; synchronizers 1 (idle-high syncs).
  - Reset mid-frame discards partial results immediately.
- Latency: an input transition first sampled at edge N produces its edge strobe at edge N+2. Dependent outputs update at edge N+3.
- o_meas_valid and o_err are high for exactly one CLOCK_50 cycle. A bad frame produces o_err in the same cycle as o_meas_valid.
- o_err_sticky rises in the cycle after the first o_err.
- Measurement quantization is ±1 tick due to async sampling, covered by TOL.

## Test plan
- Nominal 640x480@60 (1600/192 ticks, 525 lines, VS 2 lines, 480 active) → o_meas_valid once per frame with o_lines=525, o_vs_lines=2, o_active_lines=480. o_locked rises at the 2nd checked vs_fall (3rd vs_fall overall). o_err never pulses.
- Locked, then one line stretched to 1610 ticks → o_err pulse at that frame's vs_fall, o_locked drops, re-lock after 2 good frames, o_err_sticky=1.
- HS width 200 ticks (outside ±4) while other timing is nominal → never locks, o_err every frame, o_hs_ticks=200.
- Frame of 524 lines → o_lines=524, o_err pulse, lock lost.
- HS held high for 5000 ticks while locked → single o_err at tick 4095, state SEARCH, o_locked=0. Resume nominal → lock regained after 1 sync frame + 2 good frames.
- RST_N asserted mid-frame → all outputs 0 asynchronously, o_err_sticky cleared, o_frame_cnt restarts from 0.
